// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
`timescale 1ns/1ps
package regfile_pkg;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Address width for a given depth; never narrower than one bit.
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: zeroes one entry per cycle after reset or clear_req, then reports ready.
//   state    | meaning
//   RF_INIT  | clearing entry clr_cnt each edge; storage not yet usable
//   RF_READY | clear finished; reads and writes are live
`timescale 1ns/1ps
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_e     state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // rst gates the outputs combinationally so nothing is live while it is held.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ready       = 1'b0;
    clr_we      = 1'b0;
    clr_addr    = clr_cnt;
    case (state)
      RF_INIT: begin
        clr_we      = !rst;
        clr_cnt_nxt = clr_cnt + AW'(1);
        if (clr_cnt == LAST) state_nxt = RF_READY;
      end
      RF_READY: begin
        ready = !rst;
        if (clear_req) begin
          state_nxt   = RF_INIT;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = RF_INIT;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with x0 hardwiring, write bypass and clear engine.
`timescale 1ns/1ps
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = calc_aw(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_req,
  output logic                ready,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic [NWR-1:0]  wen;

  regfile_clr_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .ready     (ready),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // Effective user write enables: dropped outside READY, on a clear_req edge, and to x0.
  always_comb begin
    wen = '0;
    for (int p = 0; p < NWR; p++) begin
      wen[p] = we[p] && ready && !clear_req &&
               !((ZERO_REG != 0) && (waddr[p*AW +: AW] == '0));
    end
  end

  // Later ports overwrite earlier ones on an address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wen[p]) mem[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
      end
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = raddr[r*AW +: AW];

    always_comb begin
      rd = mem[ra];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (wen[p] && (waddr[p*AW +: AW] == ra)) rd = wdata[p*XLEN +: XLEN];
        end
      end
      if (((ZERO_REG != 0) && (ra == '0)) || !ready) rd = '0;
    end

    assign rdata[r*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: dual-write build plus a no-bypass build, scoreboard checked.
`timescale 1ns/1ps
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_req = 1'b0;
  logic        ready;
  logic [1:0]  we = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata;

  logic        nb_clear_req = 1'b0;
  logic        nb_ready;
  logic [0:0]  nb_we = '0;
  logic [4:0]  nb_waddr = '0;
  logic [31:0] nb_wdata = '0;
  logic [9:0]  nb_raddr = '0;
  logic [63:0] nb_rdata;

  always #5 clk = ~clk;

  regfile_mp #(.NWR(2)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .clear_req(nb_clear_req), .ready(nb_ready),
    .we(nb_we), .waddr(nb_waddr), .wdata(nb_wdata), .raddr(nb_raddr), .rdata(nb_rdata)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h with no expected value queued", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  // Counts edges until ready rises; 41 means it never rose within the budget.
  task automatic wait_ready(output int edges, output bit all_zero);
    edges    = 41;
    all_zero = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      #1;
      if (!ready && (rdata !== 64'd0)) all_zero = 1'b0;
      if (ready) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int k;
    bit zr;

    // 1: reset then the initial clear sequence
    @(negedge clk);
    tick();
    #1;
    push("rst_ready", 32'd0);  check({31'd0, ready});
    push("rst_rdata0", 32'd0); check(rdata[31:0]);
    push("rst_rdata1", 32'd0); check(rdata[63:32]);
    raddr = {5'd9, 5'd3};
    rst = 1'b0;
    wait_ready(k, zr);
    push("init_edges", 32'd32);    check(k);
    push("init_rdata_zero", 32'd1); check({31'd0, zr});
    push("nb_ready", 32'd1);        check({31'd0, nb_ready});
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;

    // 2: plain write/read and x0 hardwiring
    we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
    mdl[5] = 32'hDEADBEEF;
    tick();
    we = 2'b00; raddr[4:0] = 5'd5;
    #1;
    push("rd_x5", mdl[5]); check(rdata[31:0]);
    we = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'h00001234; raddr[4:0] = 5'd0;
    #1;
    push("x0_bypass", 32'd0); check(rdata[31:0]);
    tick();
    we = 2'b00;
    #1;
    push("x0_read", 32'd0); check(rdata[31:0]);

    // 3: same-cycle bypass vs no-bypass build
    we = 2'b01; waddr[4:0] = 5'd7; wdata[31:0] = 32'hA5A5A5A5; raddr[9:5] = 5'd7;
    nb_we = 1'b1; nb_waddr = 5'd7; nb_wdata = 32'hA5A5A5A5; nb_raddr[9:5] = 5'd7;
    #1;
    push("bypass_x7", 32'hA5A5A5A5); check(rdata[63:32]);
    push("nobypass_x7", mdl[7]);     check(nb_rdata[63:32]);
    mdl[7] = 32'hA5A5A5A5;
    tick();
    we = 2'b00; nb_we = 1'b0;
    #1;
    push("commit_x7", mdl[7]);    check(rdata[63:32]);
    push("nb_commit_x7", mdl[7]); check(nb_rdata[63:32]);

    // 4: two ports to the same address, higher port wins
    we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22, 32'h11}; raddr[4:0] = 5'd3;
    #1;
    push("collide_bypass", 32'h22); check(rdata[31:0]);
    mdl[3] = 32'h22;
    tick();
    we = 2'b00;
    #1;
    push("collide_commit", mdl[3]); check(rdata[31:0]);

    // 5: fill, then clear_req with a concurrent write
    for (int i = 1; i < 32; i++) begin
      we = 2'b01; waddr[4:0] = i[4:0]; wdata[31:0] = i;
      mdl[i] = i;
      tick();
    end
    we = 2'b00;
    for (int i = 0; i < 32; i++) begin
      raddr[9:5] = i[4:0];
      #1;
      push($sformatf("fill_x%0d", i), mdl[i]); check(rdata[63:32]);
    end
    clear_req = 1'b1; we = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'hFFFFFFFF;
    tick();
    clear_req = 1'b0; waddr[4:0] = 5'd4; wdata[31:0] = 32'h55;
    #1;
    push("clr_ready_low", 32'd0); check({31'd0, ready});
    wait_ready(k, zr);
    we = 2'b00;
    push("clr_edges", 32'd32);      check(k);
    push("clr_rdata_zero", 32'd1);  check({31'd0, zr});
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    for (int i = 0; i < 32; i++) begin
      raddr[4:0] = i[4:0];
      #1;
      push($sformatf("clr_x%0d", i), mdl[i]); check(rdata[31:0]);
    end

    // 6: reset in the middle of a clear restarts the sequence
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    push("midclr_rst_ready", 32'd0); check({31'd0, ready});
    tick();
    rst = 1'b0;
    wait_ready(k, zr);
    push("midclr_edges", 32'd32); check(k);

    // post-recovery write on port 1
    we = 2'b10; waddr[9:5] = 5'd12; wdata[63:32] = 32'hCAFE0012;
    mdl[12] = 32'hCAFE0012;
    tick();
    we = 2'b00; raddr[9:5] = 5'd12;
    #1;
    push("post_x12", mdl[12]); check(rdata[63:32]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
